// File: rtl/julia_iter_ctrl.sv
// Julia-set per-pixel iteration sequencer. It owns the calculation unit's
// enable, feeds each step's result back as the next z, and reports the
// escape-time iteration count to the colour stage.
module julia_iter_ctrl #(
  parameter int unsigned       FRAC_BITS = 10,
  parameter logic signed [31:0] ESC_MAG  = 32'sd4 <<< (2 * FRAC_BITS),
  parameter int unsigned       MAX_ITER  = 255,
  parameter int unsigned       ITER_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [31:0]       in_x0,
  input  logic signed [31:0]       in_y0,
  input  logic signed [31:0]       in_cr,
  input  logic signed [31:0]       in_ci,
  input  logic                     abort,
  output logic                     calc_en,
  output logic signed [31:0]       calc_x,
  output logic signed [31:0]       calc_y,
  output logic signed [31:0]       calc_cr,
  output logic signed [31:0]       calc_ci,
  input  logic                     calc_done,
  input  logic signed [31:0]       calc_xn,
  input  logic signed [31:0]       calc_yn,
  input  logic signed [31:0]       calc_mag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ITER_W-1:0]        out_iter,
  output logic                     out_escaped,
  output logic                     busy
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic signed [31:0]  z_x_q, z_y_q, c_r_q, c_i_q;
  logic [ITER_W-1:0]   iter_q;
  logic                esc_q;
  logic                accept_c;
  logic                step_c;

  // A job is taken in IDLE; a step result is taken in WAIT unless aborted
  assign accept_c = (state_q == IDLE) && in_valid;
  assign step_c   = (state_q == WAIT) && calc_done && !abort;

  // Next-state logic; abort outranks every other transition outside IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (calc_done) state_d = CHECK;
      CHECK:   state_d = (esc_q || (iter_q == ITER_LIMIT)) ? DONE : LAUNCH;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      calc_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      calc_en   <= (state_d == LAUNCH) || (state_d == WAIT);
      out_valid <= (state_d == DONE);
    end
  end

  // Job operands, running z, iteration count and escape flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_x_q  <= '0;
      z_y_q  <= '0;
      c_r_q  <= '0;
      c_i_q  <= '0;
      iter_q <= '0;
      esc_q  <= 1'b0;
    end else if (accept_c) begin
      z_x_q  <= in_x0;
      z_y_q  <= in_y0;
      c_r_q  <= in_cr;
      c_i_q  <= in_ci;
      iter_q <= '0;
      esc_q  <= 1'b0;
    end else if (step_c) begin
      z_x_q  <= calc_xn;
      z_y_q  <= calc_yn;
      iter_q <= iter_q + ITER_W'(1);
      esc_q  <= (calc_mag > ESC_MAG);
    end
  end

  // Operands and results come straight from registers, so they hold while
  // the unit is busy and while the sink stalls
  assign calc_x      = z_x_q;
  assign calc_y      = z_y_q;
  assign calc_cr     = c_r_q;
  assign calc_ci     = c_i_q;
  assign out_iter    = iter_q;
  assign out_escaped = esc_q;

endmodule
